de_pipe_reg: RTL and testbench
==============================

DE_PIPE_REG -- requirements
Module: de_pipe_reg

Interface
REQ-001 Parameter DW, default 32: width of instruction, PC, operand and immediate fields.
REQ-002 Parameter CW, default 16: width of the stall/bubble performance counters.
REQ-003 clk  in  1: single clock; all state updates on posedge clk.
REQ-004 reset  in  1: asynchronous, active-low reset (asserted when 0).
REQ-005 D_instr, D_pc, D_rs_data, D_rt_data, D_ext  in  DW each: D-stage instruction, PC, forwarded rs/rt values, extended immediate.
REQ-006 D_mduop  in  4: decoded MDU op (0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo).
REQ-007 D_valid  in  1: D-stage slot holds a real instruction.
REQ-008 Stall_data  in  1: non-MDU data-hazard stall from hazard unit.
REQ-009 Stall_mdu  in  1: MDU busy-or-starting indication.
REQ-010 D_stall  out  1: freeze PC and F/D register this cycle.
REQ-011 E_instr, E_pc, E_rs_data, E_rt_data, E_ext  out  DW each: registered E-stage fields.
REQ-012 E_mduop  out  4: registered MDU op fed to the MDU.
REQ-013 E_start  out  1: registered MDU start, one cycle per mult/div instruction.
REQ-014 E_valid  out  1: E slot holds a real instruction.
REQ-015 stall_cnt, bubble_cnt  out  CW each: saturating performance counters.

Function
REQ-016 mdu_class = D_valid and D_mduop in 1..8; mdu_hold = mdu_class and Stall_mdu.
REQ-017 D_stall SHALL be combinational: Stall_data or mdu_hold.
REQ-018 No stall: posedge loads all E fields from D, E_valid <= D_valid, E_mduop <= D_mduop if D_valid else 0.
REQ-019 E_start SHALL be 1 on that load only when D_valid and D_mduop in 1..4; otherwise 0.
REQ-020 Stall: posedge loads a bubble -- E_instr = 0 (nop), E_pc/E_rs_data/E_rt_data/E_ext = 0, E_mduop = 0, E_start = 0, E_valid = 0.
REQ-021 Stalled D instruction SHALL enter E unchanged on the first non-stall cycle; it is never dropped or duplicated.
REQ-022 Load latency D->E is exactly one cycle; each valid instruction occupies E for exactly one cycle.
REQ-023 E_start SHALL never be 1 on two consecutive cycles (Stall_mdu rises with the start, blocking the next MDU-class op).
REQ-024 Non-MDU instructions SHALL ignore Stall_mdu and advance while the MDU is busy.
REQ-025 Stall_data and mdu_hold simultaneous: single stall, single bubble per cycle.
REQ-026 stall_cnt increments by 1 each posedge with D_stall=1 and D_valid=1; holds at 2^CW-1.
REQ-027 bubble_cnt increments by 1 each posedge a bubble is loaded; holds at 2^CW-1.

Reset
REQ-028 reset=0 SHALL immediately (no clock needed) force all E outputs, E_valid, E_start, E_mduop, stall_cnt, bubble_cnt to 0.
REQ-029 Reset mid-operation discards the E instruction; no E_start is emitted during or on the first edge after reset release unless D presents mult/div without stall.
REQ-030 D_stall is combinational and may be 1 during reset if inputs demand it.

Verification
REQ-031 Plain flow: add, D_valid=1, no stalls -> next edge E_instr=D_instr, E_valid=1, E_start=0, counters 0.
REQ-032 mult with Stall_mdu=0 -> E_mduop=1, E_start=1 for one cycle; following cycle E_start=0.
REQ-033 div issued, then mflo in D with Stall_mdu=1 for 10 cycles -> D_stall=1, 10 bubbles, stall_cnt=10, bubble_cnt=10; mflo enters E with E_mduop=6 on the cycle after Stall_mdu falls.
REQ-034 Stall_mdu=1 with addu in D -> D_stall=0, addu advances, bubble_cnt unchanged.
REQ-035 Stall_data=1 and mdu_hold=1 for 3 cycles -> exactly 3 bubbles, stall_cnt=3.
REQ-036 reset=0 asserted between clock edges while E_start=1 -> E_start, E_valid, counters read 0 before next edge; CW=4 with 20 stall cycles -> stall_cnt=15.

Source files
------------

// File: rtl/de_pipe_reg.sv
// D->E pipeline register of the 5-stage core: inserts bubbles on data or MDU stalls,
// issues a one-cycle MDU start per mult/div, and keeps saturating stall/bubble counters.
module de_pipe_reg #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] D_instr,
    input  logic [DW-1:0] D_pc,
    input  logic [DW-1:0] D_rs_data,
    input  logic [DW-1:0] D_rt_data,
    input  logic [DW-1:0] D_ext,
    input  logic [3:0]    D_mduop,
    input  logic          D_valid,
    input  logic          Stall_data,
    input  logic          Stall_mdu,
    output logic          D_stall,
    output logic [DW-1:0] E_instr,
    output logic [DW-1:0] E_pc,
    output logic [DW-1:0] E_rs_data,
    output logic [DW-1:0] E_rt_data,
    output logic [DW-1:0] E_ext,
    output logic [3:0]    E_mduop,
    output logic          E_start,
    output logic          E_valid,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] bubble_cnt
);

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_t;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic mdu_class;
    logic mdu_launch;
    logic mdu_hold;

    // Any op touching HI/LO must wait for the MDU; only mult/div actually start it.
    assign mdu_class  = D_valid && (D_mduop >= MDU_MULT) && (D_mduop <= MDU_MTLO);
    assign mdu_launch = D_valid && (D_mduop >= MDU_MULT) && (D_mduop <= MDU_DIVU);
    assign mdu_hold   = mdu_class && Stall_mdu;
    assign D_stall    = Stall_data || mdu_hold;

    // NOTE: the reset branch is in the sensitivity list so outputs clear without a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            E_instr   <= '0;
            E_pc      <= '0;
            E_rs_data <= '0;
            E_rt_data <= '0;
            E_ext     <= '0;
            E_mduop   <= MDU_NONE;
            E_start   <= 1'b0;
            E_valid   <= 1'b0;
        end else if (D_stall) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            E_instr   <= '0;
            E_pc      <= '0;
            E_rs_data <= '0;
            E_rt_data <= '0;
            E_ext     <= '0;
            E_mduop   <= MDU_NONE;
            E_start   <= 1'b0;
            E_valid   <= 1'b0;
        end else begin
            E_instr   <= D_instr;
            E_pc      <= D_pc;
            E_rs_data <= D_rs_data;
            E_rt_data <= D_rt_data;
            E_ext     <= D_ext;
            E_mduop   <= D_valid ? D_mduop : MDU_NONE;
            E_start   <= mdu_launch;
            E_valid   <= D_valid;
        end
    end

    // Stalls are charged only to real instructions; every stall edge loads a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (D_stall && D_valid && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CW'(1);
            end
            if (D_stall && (bubble_cnt != CNT_MAX)) begin
                bubble_cnt <= bubble_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_de_pipe_reg.sv
// Bench for de_pipe_reg: a slot-level model is compared every falling edge,
// and directed scenarios pin the model with hand-computed values.
module tb_de_pipe_reg;

    localparam logic [31:0] ADD  = 32'h012A4020;
    localparam logic [31:0] ADDU = 32'h012A4021;
    localparam logic [31:0] MULT = 32'h01090018;
    localparam logic [31:0] DIV  = 32'h0109001A;
    localparam logic [31:0] MFLO = 32'h00004012;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] D_instr = '0, D_pc = '0, D_rs_data = '0, D_rt_data = '0, D_ext = '0;
    logic [3:0]  D_mduop = '0;
    logic        D_valid = 1'b0, Stall_data = 1'b0, Stall_mdu = 1'b0;

    logic        D_stall, E_start, E_valid;
    logic [31:0] E_instr, E_pc, E_rs_data, E_rt_data, E_ext;
    logic [3:0]  E_mduop;
    logic [15:0] stall_cnt, bubble_cnt;

    logic        D_stall4, E_start4, E_valid4;
    logic [31:0] E_instr4, E_pc4, E_rs_data4, E_rt_data4, E_ext4;
    logic [3:0]  E_mduop4;
    logic [3:0]  stall_cnt4, bubble_cnt4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    de_pipe_reg dut (
        .clk(clk), .reset(reset),
        .D_instr(D_instr), .D_pc(D_pc), .D_rs_data(D_rs_data), .D_rt_data(D_rt_data), .D_ext(D_ext),
        .D_mduop(D_mduop), .D_valid(D_valid), .Stall_data(Stall_data), .Stall_mdu(Stall_mdu),
        .D_stall(D_stall),
        .E_instr(E_instr), .E_pc(E_pc), .E_rs_data(E_rs_data), .E_rt_data(E_rt_data), .E_ext(E_ext),
        .E_mduop(E_mduop), .E_start(E_start), .E_valid(E_valid),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    de_pipe_reg #(.DW(32), .CW(4)) dut4 (
        .clk(clk), .reset(reset),
        .D_instr(D_instr), .D_pc(D_pc), .D_rs_data(D_rs_data), .D_rt_data(D_rt_data), .D_ext(D_ext),
        .D_mduop(D_mduop), .D_valid(D_valid), .Stall_data(Stall_data), .Stall_mdu(Stall_mdu),
        .D_stall(D_stall4),
        .E_instr(E_instr4), .E_pc(E_pc4), .E_rs_data(E_rs_data4), .E_rt_data(E_rt_data4), .E_ext(E_ext4),
        .E_mduop(E_mduop4), .E_start(E_start4), .E_valid(E_valid4),
        .stall_cnt(stall_cnt4), .bubble_cnt(bubble_cnt4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] instr, pc, rs, rt, ext;
        logic [3:0]  mduop;
        logic        start, valid;
    } slot_t;

    slot_t m_slot = '{default: '0};
    int    m_stall16 = 0, m_bubble16 = 0, m_stall4 = 0, m_bubble4 = 0;

    function automatic bit must_stall(input bit v, input int op, input bit sd, input bit sm);
        bit touches_hilo = v && (op >= 1) && (op <= 8);
        return sd || (touches_hilo && sm);
    endfunction

    function automatic slot_t next_slot(input bit stall);
        slot_t s = '{default: '0};
        if (!stall) begin
            s.instr = D_instr;
            s.pc    = D_pc;
            s.rs    = D_rs_data;
            s.rt    = D_rt_data;
            s.ext   = D_ext;
            s.valid = D_valid;
            s.mduop = D_valid ? D_mduop : 4'd0;
            s.start = D_valid && (D_mduop >= 1) && (D_mduop <= 4);
        end
        return s;
    endfunction

    function automatic int sat_inc(input int v, input int max);
        return (v < max) ? v + 1 : max;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_slot     <= '{default: '0};
            m_stall16  <= 0;
            m_bubble16 <= 0;
            m_stall4   <= 0;
            m_bubble4  <= 0;
        end else begin
            bit st;
            st = must_stall(D_valid, int'(D_mduop), Stall_data, Stall_mdu);
            m_slot <= next_slot(st);
            if (st && D_valid) begin
                m_stall16 <= sat_inc(m_stall16, 65535);
                m_stall4  <= sat_inc(m_stall4, 15);
            end
            if (st) begin
                m_bubble16 <= sat_inc(m_bubble16, 65535);
                m_bubble4  <= sat_inc(m_bubble4, 15);
            end
        end
    end

    // Compare process: inputs are stable mid-cycle, so falling edges are safe sample points.
    always @(negedge clk) begin
        check("D_stall",    D_stall,    must_stall(D_valid, int'(D_mduop), Stall_data, Stall_mdu));
        check("E_instr",    E_instr,    m_slot.instr);
        check("E_pc",       E_pc,       m_slot.pc);
        check("E_rs_data",  E_rs_data,  m_slot.rs);
        check("E_rt_data",  E_rt_data,  m_slot.rt);
        check("E_ext",      E_ext,      m_slot.ext);
        check("E_mduop",    E_mduop,    m_slot.mduop);
        check("E_start",    E_start,    m_slot.start);
        check("E_valid",    E_valid,    m_slot.valid);
        check("stall_cnt",  stall_cnt,  64'(m_stall16));
        check("bubble_cnt", bubble_cnt, 64'(m_bubble16));
        check("stall_cnt4", stall_cnt4, 64'(m_stall4));
        check("bubble_cnt4", bubble_cnt4, 64'(m_bubble4));
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input bit v, input logic [3:0] op, input logic [31:0] ins,
                          input bit sd, input bit sm);
        D_valid    = v;
        D_mduop    = op;
        D_instr    = ins;
        D_pc       = 32'h0040_0000 ^ {ins[29:0], 2'b00};
        D_rs_data  = ins ^ 32'h1111_0000;
        D_rt_data  = ins + 32'd7;
        D_ext      = {16'h0000, ins[15:0]};
        Stall_data = sd;
        Stall_mdu  = sm;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit v, input logic [3:0] op, input logic [31:0] ins,
                         input bit sd, input bit sm);
        set_in(v, op, ins, sd, sm);
        tick();
    endtask

    task automatic reset_pulse();
        set_in(0, 4'd0, 32'h0, 0, 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    typedef struct {
        bit          v;
        logic [3:0]  op;
        logic [31:0] ins;
        bit          sd, sm;
    } vec_t;

    vec_t table_v[10] = '{
        '{1, 4'd2, 32'h01090019, 0, 0},
        '{1, 4'd0, ADD,          0, 1},
        '{1, 4'd5, 32'h00004010, 0, 1},
        '{1, 4'd5, 32'h00004010, 0, 0},
        '{0, 4'd1, MULT,         0, 0},
        '{1, 4'd4, 32'h0109001B, 0, 0},
        '{1, 4'd7, 32'h01000011, 1, 0},
        '{1, 4'd8, 32'h01000013, 0, 0},
        '{0, 4'd0, 32'h0,        1, 1},
        '{1, 4'd0, ADDU,         0, 0}
    };

    initial begin
        tick();
        check("rst E_valid", E_valid, 0);
        check("rst E_start", E_start, 0);
        check("rst stall_cnt", stall_cnt, 0);
        reset = 1'b1;

        drive(1, 4'd0, ADD, 0, 0);
        check("add E_instr", E_instr, ADD);
        check("add E_valid", E_valid, 1);
        check("add E_start", E_start, 0);
        check("add counters", {stall_cnt, bubble_cnt}, 0);

        drive(1, 4'd1, MULT, 0, 0);
        check("mult E_mduop", E_mduop, 1);
        check("mult E_start", E_start, 1);
        set_in(1, 4'd0, ADDU, 0, 1);
        #1;
        check("addu busy D_stall", D_stall, 0);
        tick();
        check("after mult E_start", E_start, 0);
        check("addu advanced", E_instr, ADDU);
        check("addu no bubble", bubble_cnt, 0);

        drive(1, 4'd1, MULT, 0, 0);
        check("pre-reset E_start", E_start, 1);
        #1 reset = 1'b0;
        #1;
        check("async E_start", E_start, 0);
        check("async E_valid", E_valid, 0);
        check("async E_instr", E_instr, 0);
        set_in(1, 4'd0, ADD, 1, 0);
        #1;
        check("D_stall in reset", D_stall, 1);
        set_in(0, 4'd0, 32'h0, 0, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        tick();
        check("post-release E_start", E_start, 0);

        drive(1, 4'd3, DIV, 0, 0);
        check("div E_start", E_start, 1);
        check("div E_mduop", E_mduop, 3);
        for (int i = 0; i < 10; i++) drive(1, 4'd6, MFLO, 0, 1);
        check("mflo stall_cnt", stall_cnt, 10);
        check("mflo bubble_cnt", bubble_cnt, 10);
        check("mflo held E_valid", E_valid, 0);
        drive(1, 4'd6, MFLO, 0, 0);
        check("mflo E_instr", E_instr, MFLO);
        check("mflo E_mduop", E_mduop, 6);
        check("mflo E_start", E_start, 0);

        for (int i = 0; i < 3; i++) drive(1, 4'd6, MFLO, 1, 1);
        check("dual stall_cnt", stall_cnt, 13);
        check("dual bubble_cnt", bubble_cnt, 13);

        reset_pulse();
        for (int i = 0; i < 20; i++) drive(1, 4'd0, ADD, 1, 0);
        check("sat stall_cnt4", stall_cnt4, 15);
        check("wide stall_cnt", stall_cnt, 20);
        for (int i = 0; i < 2; i++) drive(0, 4'd0, 32'h0, 1, 0);
        check("empty bubble_cnt", bubble_cnt, 22);
        check("empty stall_cnt", stall_cnt, 20);
        check("sat bubble_cnt4", bubble_cnt4, 15);

        foreach (table_v[i]) drive(table_v[i].v, table_v[i].op, table_v[i].ins, table_v[i].sd, table_v[i].sm);
        check("last E_instr", E_instr, ADDU);

        set_in(0, 4'd0, 32'h0, 0, 0);
        tick();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
